// File: rtl/pipeline_stall_controller.sv
// Central freeze/flush sequencer for the 5-stage pipeline.
// Merges the load-use hazard, taken branches, SRAM wait states and multi-cycle
// EXE ops into per-stage hold/clear controls, and keeps saturating stall/flush
// counters plus a sticky memory-timeout flag.
module pipeline_stall_controller #(
   parameter int EXE_CYCLES  = 3,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard_detected,
   input  logic             branch_taken,
   input  logic             mem_access,
   input  logic             sram_ready,
   input  logic             exe_multi,
   output logic             freeze_pc,
   output logic             freeze_if_id,
   output logic             flush_if_id,
   output logic             freeze_id_exe,
   output logic             flush_id_exe,
   output logic             bubble_exe_mem,
   output logic             freeze_exe_mem,
   output logic             freeze_mem_wb,
   output logic             freeze_exe,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   // exe_cnt holds EXE_CYCLES-2 at most; wait_cnt must be able to reach MEM_TIMEOUT
   localparam int EXE_W  = (EXE_CYCLES > 2) ? $clog2(EXE_CYCLES) : 1;
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MEM_WAIT,
      ST_EXE_BUSY
   } state_t;

   state_t            state;
   logic [EXE_W-1:0]  exe_cnt;
   logic [WAIT_W-1:0] wait_cnt;

   logic mem_stall;
   logic exe_stall;
   logic back_stall;
   logic br;
   logic hz;

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
      return (&v) ? v : v + WAIT_W'(1);
   endfunction

   // Stall sources and the per-stage controls derived from them, same cycle as inputs
   always_comb begin
      mem_stall = mem_access & ~sram_ready;
      exe_stall = 1'b0;
      case (state)
         // a coincident memory stall defers the multi-cycle op until RUN resumes
         ST_RUN:      exe_stall = exe_multi & ~mem_stall;
         ST_EXE_BUSY: exe_stall = (exe_cnt != '0);
         default:     exe_stall = 1'b0;
      endcase
      back_stall = mem_stall | exe_stall;
      // a taken branch squashes the hazarding ID instruction, so the hazard is dropped
      br = branch_taken & ~back_stall;
      hz = hazard_detected & ~br & ~back_stall;

      // everything is forced low while reset is asserted, whatever the inputs do
      freeze_pc      = ~rst & (back_stall | hz);
      freeze_if_id   = ~rst & (back_stall | hz);
      flush_if_id    = ~rst & br;
      flush_id_exe   = ~rst & (br | hz);
      freeze_id_exe  = ~rst & back_stall;
      bubble_exe_mem = ~rst & exe_stall & ~mem_stall;
      freeze_exe_mem = ~rst & mem_stall;
      freeze_mem_wb  = ~rst & mem_stall;
      freeze_exe     = ~rst & exe_stall;
   end

   // Sequencer state, wait/occupancy counters and sticky timeout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_RUN;
         exe_cnt     <= '0;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (mem_stall) begin
                  state    <= ST_MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
                  if (MEM_TIMEOUT <= 1) mem_timeout <= 1'b1;
               end else if (exe_multi) begin
                  state   <= ST_EXE_BUSY;
                  exe_cnt <= EXE_W'(EXE_CYCLES - 2);
               end
            end
            ST_MEM_WAIT: begin
               if (sram_ready) begin
                  state    <= ST_RUN;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= sat_inc_wait(wait_cnt);
                  // flag is raised as the count reaches the limit; waiting continues
                  if (int'(sat_inc_wait(wait_cnt)) >= MEM_TIMEOUT) mem_timeout <= 1'b1;
               end
            end
            ST_EXE_BUSY: begin
               // a memory stall freezes the op in place with its count held
               if (!mem_stall) begin
                  if (exe_cnt != '0) exe_cnt <= exe_cnt - EXE_W'(1);
                  else               state   <= ST_RUN;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   // Saturating performance counters for PC stalls and IF/ID flushes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (freeze_pc)   stall_cycles <= sat_inc_cnt(stall_cycles);
         if (flush_if_id) flush_count  <= sat_inc_cnt(flush_count);
      end
   end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_pipeline_stall_controller;

   localparam int EXE_CYCLES  = 3;
   localparam int MEM_TIMEOUT = 8;
   localparam int CNT_W       = 6;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic             hazard_detected;
   logic             branch_taken;
   logic             mem_access;
   logic             sram_ready;
   logic             exe_multi;
   logic             freeze_pc;
   logic             freeze_if_id;
   logic             flush_if_id;
   logic             freeze_id_exe;
   logic             flush_id_exe;
   logic             bubble_exe_mem;
   logic             freeze_exe_mem;
   logic             freeze_mem_wb;
   logic             freeze_exe;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   int checks   = 0;
   int failures = 0;

   // behavioural model state
   bit m_wait;      // waiting for SRAM
   int m_waited;    // cycles spent waiting so far
   bit m_busy;      // multi-cycle op occupying EXE
   int m_occ;       // EXE cycles already consumed by the op
   bit m_to;
   int m_stall;
   int m_flush;

   pipeline_stall_controller #(
      .EXE_CYCLES (EXE_CYCLES),
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .hazard_detected(hazard_detected),
      .branch_taken   (branch_taken),
      .mem_access     (mem_access),
      .sram_ready     (sram_ready),
      .exe_multi      (exe_multi),
      .freeze_pc      (freeze_pc),
      .freeze_if_id   (freeze_if_id),
      .flush_if_id    (flush_if_id),
      .freeze_id_exe  (freeze_id_exe),
      .flush_id_exe   (flush_id_exe),
      .bubble_exe_mem (bubble_exe_mem),
      .freeze_exe_mem (freeze_exe_mem),
      .freeze_mem_wb  (freeze_mem_wb),
      .freeze_exe     (freeze_exe),
      .mem_timeout    (mem_timeout),
      .stall_cycles   (stall_cycles),
      .flush_count    (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [8:0] ctl_vec();
      return {freeze_pc, freeze_if_id, flush_if_id, freeze_id_exe, flush_id_exe,
              bubble_exe_mem, freeze_exe_mem, freeze_mem_wb, freeze_exe};
   endfunction

   task automatic model_reset();
      m_wait = 0; m_waited = 0; m_busy = 0; m_occ = 0;
      m_to = 0; m_stall = 0; m_flush = 0;
   endtask

   // One clock cycle: apply inputs, check outputs mid-cycle, advance the model
   task automatic step(input bit hz, input bit br, input bit ma, input bit sr, input bit em);
      bit ms, es, bs, b, h;
      logic [8:0] exp;
      hazard_detected = hz;
      branch_taken    = br;
      mem_access      = ma;
      sram_ready      = sr;
      exe_multi       = em;
      @(negedge clk);
      ms = ma && !sr;
      if (m_busy)      es = (m_occ < EXE_CYCLES - 1);
      else if (m_wait) es = 0;
      else             es = em && !ms;
      bs = ms || es;
      b  = br && !bs;
      h  = hz && !b && !bs;
      exp = {bs | h, bs | h, b, bs, b | h, es & !ms, ms, ms, es};
      check("ctl", 32'(ctl_vec()), 32'(exp));
      check("mem_timeout", 32'(mem_timeout), 32'(m_to));
      check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
      check("flush_count", 32'(flush_count), 32'(m_flush));
      // advance model to the next cycle
      if (bs || h) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      if (b)       m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
      if (m_busy) begin
         if (!ms) begin
            if (m_occ < EXE_CYCLES - 1) m_occ++;
            else m_busy = 0;
         end
      end else if (m_wait) begin
         if (sr) m_wait = 0;
         else begin
            m_waited++;
            if (m_waited >= MEM_TIMEOUT) m_to = 1;
         end
      end else if (ms) begin
         m_wait = 1;
         m_waited = 1;
         if (m_waited >= MEM_TIMEOUT) m_to = 1;
      end else if (em) begin
         m_busy = 1;
         m_occ = 1;
      end
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset pulse with arbitrary inputs; outputs must drop at once
   task automatic do_reset();
      hazard_detected = 1'($urandom); branch_taken = 1'($urandom);
      mem_access = 1'($urandom); sram_ready = 1'($urandom); exe_multi = 1'($urandom);
      #1;
      rst = 1'b1;
      #1;
      check("rst_ctl", 32'(ctl_vec()), 32'h0);
      check("rst_tmo", 32'(mem_timeout), 32'h0);
      check("rst_cnt", 32'({stall_cycles, flush_count}), 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("rst_hold_ctl", 32'(ctl_vec()), 32'h0);
      hazard_detected = 0; branch_taken = 0; mem_access = 0; sram_ready = 0; exe_multi = 0;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      hazard_detected = 0; branch_taken = 0; mem_access = 0; sram_ready = 0; exe_multi = 0;
      model_reset();
      #2;
      do_reset();

      // load-use hazard alone
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("t1_stall_cnt", 32'(stall_cycles), 32'd1);

      // taken branch overrides a hazard
      do_reset();
      step(1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("t2_flush_cnt", 32'(flush_count), 32'd1);
      check("t2_stall_cnt", 32'(stall_cycles), 32'd0);

      // four SRAM wait cycles, then ready; branch/hazard masked meanwhile
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 1);
      step(0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0);

      // multi-cycle EXE op, then back-to-back op with a memory stall inside it
      do_reset();
      step(0, 0, 0, 1, 1);
      step(0, 1, 0, 1, 1);
      step(1, 0, 0, 1, 1);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);

      // coincident memory stall and multi op: memory first, op on return
      step(0, 0, 1, 0, 1);
      step(0, 0, 1, 1, 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);

      // SRAM timeout: sticky until reset
      do_reset();
      for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0);
      check("t5_tmo_held", 32'(mem_timeout), 32'd1);

      // reset mid-EXE_BUSY and mid-MEM_WAIT
      step(0, 0, 0, 1, 1);
      do_reset();
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      do_reset();
      step(0, 0, 0, 1, 0);

      // randomized traffic, long enough to saturate both counters
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         else step(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 7),
                   ($urandom_range(0, 9) < 2));
      end

      // long stall run to exercise saturation and timeout after random traffic
      for (int i = 0; i < 80; i++) step(1, 1, 1, 0, 1);
      step(0, 0, 0, 1, 0);
      check("sat_stall", 32'(stall_cycles), 32'(CNT_MAX));
      check("tmo_final", 32'(mem_timeout), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
